fcl_multi_controller: RTL
=========================

Name: fcl_multi_controller

Overview:
Parametrised controller in front of the field config loader (FCL). It accepts load requests for NUM_CFGS configurations and arbitrates simultaneous requests by priority. It holds a request until the FCL is allowed to run, issues a one-cycle go pulse and then tracks the loader through a start-acknowledge window and a completion timeout. A single-entry pending slot captures a request that arrives while a load is in flight, and a cancel input drops queued work.

Parameters:
NUM_CFGS, 4, number of selectable configurations (>=2)
IDX_W, $clog2(NUM_CFGS), width of config index (derived; not overridden)
ACK_WINDOW, 4, cycles after go to wait for i_is_loading to rise before treating the load as instantly complete (>=1)
TIMEOUT_CYCLES, 1024, max cycles in WAIT_END before aborting; 0 disables timeout
CNT_W, 16, width of internal wait counter; TIMEOUT_CYCLES and ACK_WINDOW must be < 2**CNT_W

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_cmd_load_cfg  input  NUM_CFGS  one-hot-ish request strobes; bit k requests config k
i_cancel  input  1  drop latched/pending request
i_FCL_allowed  input  1  FCL may start a load this cycle
i_is_loading  input  1  loader busy indicator
o_go  output  1  one-cycle start pulse to loader
o_cfg_idx  output  IDX_W  config index of current request; stable from ARMED through completion
o_req_valid  output  1  a request is latched (state != IDLE)
o_pending_valid  output  1  pending slot occupied
o_busy  output  1  state in START, WAIT_ACK or WAIT_END
o_done  output  1  one-cycle pulse, load completed normally
o_timeout  output  1  sticky; set on timeout abort, cleared on next o_go

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, counter 0, pending slot empty.
- Request decode: if several i_cmd_load_cfg bits are high, the lowest index wins. An all-zero vector means no request.
- States: IDLE, ARMED, START, WAIT_ACK, WAIT_END.
- IDLE: a nonzero cmd latches its index and moves to ARMED next cycle. i_cancel is ignored.
- ARMED:
  - i_cancel has priority: go to IDLE and clear o_req_valid. The pending slot is already empty here.
  - Otherwise a nonzero cmd overwrites the index (last-writer-wins).
  - If i_FCL_allowed=1, go to START. Any cmd seen the same cycle is used as the go index.
- START: o_go=1 for exactly this cycle. Counter is cleared. Next state is WAIT_ACK unconditionally.
- WAIT_ACK:
  - i_is_loading=1 -> WAIT_END with counter cleared.
  - Otherwise the counter increments. When it reaches ACK_WINDOW-1 with i_is_loading still 0, this is a normal completion.
- WAIT_END:
  - i_is_loading=0 -> normal completion.
  - Otherwise the counter increments. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with i_is_loading still 1, this is a timeout abort.
- Normal completion: o_done=1 on the following cycle.
- Timeout abort: o_timeout=1 from the following cycle (sticky). o_done is not asserted.
- After completion or abort:
  - If pending is valid: the pending index moves to the current index, pending is cleared and the state goes to ARMED.
  - Otherwise: state goes to IDLE and o_req_valid drops.
- Pending slot (START/WAIT_ACK/WAIT_END):
  - A nonzero cmd writes the pending slot (overwrite; lowest-index priority).
  - i_cancel clears the slot. When cancel and cmd arrive in the same cycle, cancel wins.
  - The in-flight load is never cancelled.
  - A cmd arriving in the completion cycle is still captured and becomes the next ARMED index.
- o_cfg_idx holds its last value in IDLE. It must not change while o_busy=1.
- Latency, cmd to o_go with i_FCL_allowed held high: cmd at cycle N, ARMED at N+1, o_go at N+2.
- i_is_loading high while in IDLE/ARMED has no effect.
- Reset mid-load drops everything. No go is re-issued.

Test Plan:
- Single request: cmd=4'b0100 at cycle 0, allowed=1, loader raises is_loading at 3 and drops at 10 -> o_go at 2 with idx=2; WAIT_END at 4; o_done at 11; o_req_valid=0 from 11.
- Priority and override: cmd=4'b1010 while allowed=0 -> idx=1. Then cmd=4'b1000 in ARMED -> idx=3. Raising allowed -> o_go with idx=3.
- Pending plus cancel: cmd=0001 -> load in flight; cmd=0100 during WAIT_END -> o_pending_valid=1. On completion, ARMED with idx=2. Repeat with i_cancel during WAIT_END -> after o_done, IDLE, no second go.
- No-ack: go issued, is_loading stays 0 -> o_done 1 cycle after ACK_WINDOW cycles in WAIT_ACK (ACK_WINDOW=4: go at 2, done at 7).
- Timeout: TIMEOUT_CYCLES=8, is_loading stuck 1 -> o_timeout=1 after 8 WAIT_END cycles, no o_done, IDLE. A new request -> o_timeout clears on its o_go. With TIMEOUT_CYCLES=0 the controller waits indefinitely.
- Async reset asserted in WAIT_END with pending valid -> all outputs 0 immediately; after release, no o_go without a new cmd.

Source files
------------

// File: rtl/fcl_multi_controller_if.sv
// Request/handshake bundle between a requester/loader side and fcl_multi_controller.
//   i_cmd_load_cfg  : per-config request strobes (bit k requests config k)
//   i_cancel        : drop latched/pending request
//   i_FCL_allowed   : loader may start this cycle
//   i_is_loading    : loader busy indicator
//   o_go            : one-cycle start pulse to loader
//   o_cfg_idx       : index of the current request
//   o_req_valid     : a request is latched
//   o_pending_valid : pending slot occupied
//   o_busy          : load in flight (START/WAIT_ACK/WAIT_END)
//   o_done          : one-cycle normal-completion pulse
//   o_timeout       : sticky timeout flag, cleared on the next go
// master = requester/loader side, slave = controller side.
interface fcl_multi_controller_if #(
    parameter int unsigned NUM_CFGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_CFGS)
);
    logic [NUM_CFGS-1:0] i_cmd_load_cfg;
    logic                i_cancel;
    logic                i_FCL_allowed;
    logic                i_is_loading;
    logic                o_go;
    logic [IDX_W-1:0]    o_cfg_idx;
    logic                o_req_valid;
    logic                o_pending_valid;
    logic                o_busy;
    logic                o_done;
    logic                o_timeout;

    modport master (
        output i_cmd_load_cfg, i_cancel, i_FCL_allowed, i_is_loading,
        input  o_go, o_cfg_idx, o_req_valid, o_pending_valid, o_busy, o_done, o_timeout
    );

    modport slave (
        input  i_cmd_load_cfg, i_cancel, i_FCL_allowed, i_is_loading,
        output o_go, o_cfg_idx, o_req_valid, o_pending_valid, o_busy, o_done, o_timeout
    );
endinterface

// File: rtl/fcl_multi_controller.sv
// Controller in front of the field config loader: arbitrates config load requests
// (lowest index wins), waits for permission, pulses go, then tracks the loader
// through a start-acknowledge window and an optional completion timeout. A single
// pending slot holds a request that arrives while a load is in flight.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fcl_multi_controller_if.slave (requests in, status/go out)
module fcl_multi_controller #(
    parameter int unsigned NUM_CFGS       = 4,
    parameter int unsigned ACK_WINDOW     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fcl_multi_controller_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(NUM_CFGS);
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_WINDOW - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_WAIT_END = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic             go_q, go_d;
    logic             req_valid_q, req_valid_d;
    logic             busy_q, busy_d;

    logic             cmd_any;
    logic [IDX_W-1:0] cmd_idx;
    logic             finish;
    logic             abort;

    // Lowest set bit wins.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CFGS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = NUM_CFGS - 1; k >= 0; k--) begin
            if (v[k]) r = IDX_W'(k);
        end
        return r;
    endfunction

    assign cmd_any = |bus.i_cmd_load_cfg;
    assign cmd_idx = lowest_idx(bus.i_cmd_load_cfg);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_idx_d   = pend_idx_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        done_d       = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_any) begin
                    idx_d   = cmd_idx;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.i_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (cmd_any) idx_d = cmd_idx;
                    if (bus.i_FCL_allowed) state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.i_is_loading) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_END;
                end else if (cnt_q == ACK_LAST) begin
                    // Loader never acknowledged: treat as an instant load.
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_END: begin
                if (!bus.i_is_loading) begin
                    finish = 1'b1;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    abort = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pending slot while a load is in flight; cancel beats a same-cycle cmd.
        if ((state_q == S_START) || (state_q == S_WAIT_ACK) || (state_q == S_WAIT_END)) begin
            if (bus.i_cancel) begin
                pend_valid_d = 1'b0;
            end else if (cmd_any) begin
                pend_valid_d = 1'b1;
                pend_idx_d   = cmd_idx;
            end
        end

        // End of load: promote pending (including a cmd seen this cycle) or go idle.
        if (finish || abort) begin
            done_d = finish;
            if (abort) timeout_d = 1'b1;
            if (pend_valid_d) begin
                idx_d        = pend_idx_d;
                pend_valid_d = 1'b0;
                state_d      = S_ARMED;
            end else begin
                state_d = S_IDLE;
            end
        end

        go_d        = (state_d == S_START);
        if (go_d) timeout_d = 1'b0;
        req_valid_d = (state_d != S_IDLE);
        busy_d      = (state_d == S_START) || (state_d == S_WAIT_ACK) || (state_d == S_WAIT_END);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pend_idx_q   <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            go_q         <= 1'b0;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_idx_q   <= pend_idx_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            go_q         <= go_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.o_go            = go_q;
    assign bus.o_cfg_idx       = idx_q;
    assign bus.o_req_valid     = req_valid_q;
    assign bus.o_pending_valid = pend_valid_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_done          = done_q;
    assign bus.o_timeout       = timeout_q;
endmodule
